// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Sequential unsigned N-bit restoring divider, one quotient bit
//               per clock, with divide-by-zero short path.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam int              c_cnt_w    = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [N-1:0]       r_r;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dbz;
    logic               r_done;
    logic [N-1:0]       r_quotient;
    logic [N-1:0]       r_remainder;
    logic               r_div_by_zero;

    logic [N:0]         w_rs;
    logic [N:0]         w_nd;
    logic [N:0]         w_t;
    logic               w_cout;

    // Partial remainder is always < 2*D, so the N+1-bit difference never
    // wraps and its sign bit is exactly the inverted carry-out.
    assign w_rs   = {r_r, r_q[N-1]};
    assign w_nd   = ~{1'b0, r_d};
    assign w_t    = w_rs + w_nd + {{N{1'b0}}, 1'b1};
    assign w_cout = ~w_t[N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_next = (divisor == '0) ? c_done : c_calc;
                end
            end
            c_calc: begin
                if (r_cnt == c_cnt_last) begin
                    w_next = c_done;
                end
            end
            c_done:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_r           <= '0;
            r_q           <= '0;
            r_d           <= '0;
            r_cnt         <= '0;
            r_dbz         <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_d   <= divisor;
                        r_cnt <= '0;
                        // Zero divisor preloads the final result so the
                        // DONE edge publishes it unchanged.
                        if (divisor == '0) begin
                            r_q   <= '1;
                            r_r   <= dividend;
                            r_dbz <= 1'b1;
                        end else begin
                            r_q   <= dividend;
                            r_r   <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                c_calc: begin
                    r_r   <= w_cout ? w_t[N-1:0] : w_rs[N-1:0];
                    r_q   <= {r_q[N-2:0], w_cout};
                    r_cnt <= r_cnt + c_cnt_one;
                end
                c_done: begin
                    r_quotient    <= r_q;
                    r_remainder   <= r_r;
                    r_div_by_zero <= r_dbz;
                    r_done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != c_idle);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
